// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the oversampled UART receiver:
//               FSM state encoding, oversampling constants and a helper that
//               sizes the sample-tick counter from the stop-bit length.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Two stop bits need 32 ticks, which no longer fits a 4-bit counter.
    function automatic int cnt_width(input int sb_tick);
        return (sb_tick > 16) ? 5 : 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-flop synchronizer for the asynchronous Rx pin. Resets
//               to 1 so the chain matches an idle (high) line.
// Ports       : Clk    in  system clock
//               Rst_n  in  asynchronous active-low reset
//               d_in   in  raw asynchronous input
//               q_out  out synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 16x-oversampled UART receiver. Detects the start edge,
//               confirms it at mid-start-bit, samples each data bit mid-bit
//               (LSB first) and checks the stop bit. Good frames update
//               RxData with a one-cycle RxDone; bad stop bits give a
//               one-cycle FrameErr and leave RxData untouched.
// Ports       : Clk      in  system clock
//               Rst_n    in  asynchronous active-low reset
//               Tick     in  16x-baud enable, one Clk wide
//               Rx       in  raw serial input, idle high
//               RxData   out last good byte
//               RxDone   out one-cycle pulse, RxData valid
//               FrameErr out one-cycle pulse, stop bit was low
//               Busy     out receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DBIT        = 8,
    parameter int SB_TICK     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Tick,
    input  logic            Rx,
    output logic [DBIT-1:0] RxData,
    output logic            RxDone,
    output logic            FrameErr,
    output logic            Busy
);

    import uart_pkg::*;

    localparam int CW = cnt_width(SB_TICK);
    localparam int NW = $clog2(DBIT);

    localparam logic [CW-1:0] C_MID_CNT  = CW'(MID_TICK);
    localparam logic [CW-1:0] C_BIT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_STOP_END = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] C_LAST_BIT = NW'(DBIT - 1);

    logic            rx_s;
    logic [1:0]      state_q,    state_d;
    logic [CW-1:0]   s_cnt_q,    s_cnt_d;
    logic [NW-1:0]   n_cnt_q,    n_cnt_d;
    logic [DBIT-1:0] shreg_q,    shreg_d;
    logic [DBIT-1:0] rx_data_q,  rx_data_d;
    logic            armed_q,    armed_d;
    logic            rx_done_q,  rx_done_d;
    logic            frame_err_q, frame_err_d;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .d_in  (Rx),
        .q_out (rx_s)
    );

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            armed_q     <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            armed_q     <= armed_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Edge detection runs every Clk; only the counting needs Tick.
                if (armed_q && !rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (Tick) begin
                    if (s_cnt_q == C_MID_CNT) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (s_cnt_q == C_BIT_END) begin
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == C_LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    if (s_cnt_q == C_STOP_END) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A line held low (break) must go high once before a new frame
        // can start, so arming only happens while sitting in IDLE.
        if (state_d != IDLE) begin
            armed_d = 1'b0;
        end else if (state_q == IDLE && rx_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Outputs
    always_comb begin
        RxData   = rx_data_q;
        RxDone   = rx_done_q;
        FrameErr = frame_err_q;
        Busy     = (state_q != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Self-checking bench for uart_rx_oversampled. A serial driver
//               sends frames (directed and random); each frame pushes its
//               expected outcome into a queue and a monitor compares every
//               RxDone/FrameErr pulse against the head of that queue.
//               Tick is every 4 Clk, so a nominal bit is 64 Clk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Tick  = 1'b0;
    logic       Rx    = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;
    int         tick_div  = 0;

    uart_rx_oversampled #(
        .DBIT        (8),
        .SB_TICK     (16),
        .SYNC_STAGES (2)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Tick     (Tick),
        .Rx       (Rx),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            @(negedge Clk);
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            Tick = (tick_div == 0);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every pulse is compared against the oldest outstanding frame.
    always @(negedge Clk) begin
        if (Rst_n && (RxDone || FrameErr)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {22'd0, FrameErr, RxDone, RxData}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_result", {22'd0, FrameErr, RxDone, RxData},
                    {22'd0, e.err, ~e.err, e.data});
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Sends one 8N1 frame with bclk Clk per bit. rst_bit >= 0 pulses reset
    // in the middle of that data bit and abandons the frame (line idles high).
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int bclk, input int rst_bit);
        exp_t e;
        if (rst_bit < 0) begin
            if (stop_ok) last_good = d;
            e.err  = !stop_ok;
            e.data = last_good;
            exp_q.push_back(e);
        end
        Rx = 1'b0;
        hold(bclk);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            if (i == rst_bit) begin
                hold(bclk / 2);
                Rst_n = 1'b0;
                last_good = 8'h00;
                for (int k = 0; k < 3; k++) begin
                    hold(1);
                    chk("reset_mid_frame", {RxData, RxDone, FrameErr, Busy}, 0);
                end
                Rst_n = 1'b1;
                Rx = 1'b1;
                hold(bclk * (10 - i));
                return;
            end
            hold(bclk);
        end
        Rx = stop_ok;
        hold(bclk);
    endtask

    initial begin
        // Reset state
        hold(3);
        chk("reset_state", {RxData, RxDone, FrameErr, Busy}, 0);
        Rst_n = 1'b1;
        Rx = 1'b1;
        hold(100);

        // 1) Single good frame
        send_frame(8'hA5, 1'b1, 64, -1);
        hold(40);
        chk("a5_done_busy", {exp_q.size(), 1'b0, Busy}, 0);

        // 2) Short glitch on the line
        Rx = 1'b0;
        hold(20);
        Rx = 1'b1;
        hold(150);
        chk("glitch_idle", {exp_q.size(), 1'b0, Busy}, 0);

        // 3) Framing error, then a break that must not retrigger
        send_frame(8'h3C, 1'b0, 64, -1);
        Rx = 1'b0;
        hold(160);
        chk("break_not_busy", {exp_q.size(), 1'b0, Busy}, 0);
        hold(160);
        Rx = 1'b1;
        hold(100);
        chk("break_no_frame", {exp_q.size(), 1'b0, Busy}, 0);

        // 4) Back-to-back frames
        send_frame(8'h00, 1'b1, 64, -1);
        send_frame(8'hFF, 1'b1, 64, -1);
        send_frame(8'h55, 1'b1, 64, -1);
        hold(100);
        chk("b2b_drained", exp_q.size(), 0);

        // 5) Reset during bit 4, then a clean frame
        send_frame(8'h81, 1'b1, 64, 4);
        hold(100);
        chk("after_reset_idle", {exp_q.size(), 1'b0, Busy}, 0);
        chk("after_reset_data", {24'd0, RxData}, 0);
        send_frame(8'h81, 1'b1, 64, -1);
        hold(100);

        // 6) Baud mismatch of about +/-3%
        send_frame(8'h96, 1'b1, 62, -1);
        hold(50);
        send_frame(8'h96, 1'b1, 66, -1);
        hold(100);
        chk("baud_drained", exp_q.size(), 0);

        // Random frames with occasional bad stop bits and random gaps
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         ok;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, $urandom_range(63, 65), -1);
            Rx = 1'b1;
            hold($urandom_range(0, 40) + (ok ? 0 : 20));
        end
        hold(200);
        chk("final_drained", {exp_q.size(), 1'b0, Busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
